// File: rtl/mem_region_addr_gen_if.sv
// ---------------------------------------------------------------------------
// mem_region_addr_gen_if
// Bundles the configuration, burst-request and address-stream signals of the
// DRAM region address generator.
//   master : layer controller / DMA side (drives cfg_*, req_*, addr_ready)
//   slave  : the address generator itself
// Signals:
//   cfg_we, cfg_idx, cfg_base_mb, cfg_ready        base-register writes
//   req_valid, req_ready, req_region, req_off,
//   req_len, req_stride                            burst request
//   addr_valid, addr_ready, addr, addr_last        address beat stream
//   done, err                                      burst completion pulses
// ---------------------------------------------------------------------------
interface mem_region_addr_gen_if #(
  parameter int N_REG  = 7,
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 16,
  parameter int MB_W   = 8
);
  localparam int RW = (N_REG > 1) ? $clog2(N_REG) : 1;

  logic              cfg_we;
  logic [RW-1:0]     cfg_idx;
  logic [MB_W-1:0]   cfg_base_mb;
  logic              cfg_ready;

  logic              req_valid;
  logic              req_ready;
  logic [RW-1:0]     req_region;
  logic [ADDR_W-1:0] req_off;
  logic [LEN_W-1:0]  req_len;
  logic [ADDR_W-1:0] req_stride;

  logic              addr_valid;
  logic              addr_ready;
  logic [ADDR_W-1:0] addr;
  logic              addr_last;

  logic              done;
  logic              err;

  modport master (
    output cfg_we, cfg_idx, cfg_base_mb,
    output req_valid, req_region, req_off, req_len, req_stride,
    output addr_ready,
    input  cfg_ready, req_ready, addr_valid, addr, addr_last, done, err
  );

  modport slave (
    input  cfg_we, cfg_idx, cfg_base_mb,
    input  req_valid, req_region, req_off, req_len, req_stride,
    input  addr_ready,
    output cfg_ready, req_ready, addr_valid, addr, addr_last, done, err
  );
endinterface

// File: rtl/mem_region_addr_gen.sv
// ---------------------------------------------------------------------------
// mem_region_addr_gen
// DRAM address generator for the accelerator memory map (conv info, FMI, FMO,
// KEX, KPW, KDW, stop). Holds per-region base registers in MiB, bounds-checks
// burst requests against the region size and streams byte addresses.
//
// Ports:
//   clk    clock
//   rst_n  synchronous active-low reset
//   bus    mem_region_addr_gen_if.slave:
//            cfg_*  base-register write (accepted in IDLE only)
//            req_*  burst request (region, offset, length, stride)
//            addr_* address beat stream with valid/ready and last flag
//            done   one-cycle pulse at burst end; err coincident on bounds fail
//
// Build option:
//   ADDR_WRAP_EN  when defined, beats wrap modulo the region size instead of
//                 rejecting bursts that run past the region limit; only the
//                 start offset and the stride are bounds-checked.
// ---------------------------------------------------------------------------
module mem_region_addr_gen #(
  parameter int          N_REG  = 7,
  parameter int          ADDR_W = 32,
  parameter int          LEN_W  = 16,
  parameter int          MB_W   = 8,
  parameter int unsigned DEF_BASE_MB [N_REG] = '{0, 2, 24, 46, 66, 84, 103},
  parameter int          MEM_MB = 128
) (
  input logic                  clk,
  input logic                  rst_n,
  mem_region_addr_gen_if.slave bus
);

  localparam int RW = (N_REG > 1) ? $clog2(N_REG) : 1;
  localparam int EW = ADDR_W + LEN_W;
  localparam logic [ADDR_W-1:0] MEM_BYTES = ADDR_W'(MEM_MB) << 20;

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_BURST} state_e;

  function automatic logic [ADDR_W-1:0] mb_to_byte(input logic [MB_W-1:0] mb);
    return ADDR_W'(mb) << 20;
  endfunction

  // Last byte offset touched by the burst, wide enough that it never wraps.
  function automatic logic [EW-1:0] burst_end(input logic [ADDR_W-1:0] off,
                                              input logic [LEN_W-1:0]  len,
                                              input logic [ADDR_W-1:0] stride);
    logic [LEN_W-1:0] nm1;
    nm1 = len - 1'b1;
    return EW'(off) + EW'(nm1) * EW'(stride);
  endfunction

  state_e            state_q, state_d;
  logic [MB_W-1:0]   base_q [N_REG];
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic [RW-1:0]     region_q;
  logic [ADDR_W-1:0] off_q;
  logic [LEN_W-1:0]  len_q;
  logic [ADDR_W-1:0] stride_q;
  logic [ADDR_W-1:0] cur_q, cur_d;
  logic [LEN_W-1:0]  cnt_q;

  logic [ADDR_W-1:0] lim_byte [N_REG];
  logic [ADDR_W-1:0] reg_size [N_REG];
  logic [ADDR_W-1:0] sel_base, sel_size;
  logic              len_zero, range_err, last_beat;

  // Region geometry: limit is the next region's base; a non-monotonic map
  // leaves an empty region rather than a huge wrapped one.
  always_comb begin
    for (int i = 0; i < N_REG; i++) lim_byte[i] = MEM_BYTES;
    for (int i = 0; i < N_REG - 1; i++) lim_byte[i] = mb_to_byte(base_q[i+1]);
    for (int i = 0; i < N_REG; i++) begin
      reg_size[i] = (lim_byte[i] > mb_to_byte(base_q[i]))
                    ? lim_byte[i] - mb_to_byte(base_q[i]) : '0;
    end
  end

  // Out-of-range region indices match nothing and so see size 0.
  always_comb begin
    sel_base = '0;
    sel_size = '0;
    for (int i = 0; i < N_REG; i++) begin
      if (region_q == RW'(i)) begin
        sel_base = mb_to_byte(base_q[i]);
        sel_size = reg_size[i];
      end
    end
  end

  assign len_zero  = (len_q == '0);
  assign last_beat = (cnt_q == len_q - 1'b1);

`ifdef ADDR_WRAP_EN
  logic [ADDR_W-1:0] wbase_q, wsize_q, woff_q, woff_d;
  logic [ADDR_W:0]   wsum;

  assign range_err = (sel_size == '0) || (off_q >= sel_size) || (stride_q >= sel_size);

  // Offset and stride are both below size, so one subtract restores range.
  always_comb begin
    wsum   = {1'b0, woff_q} + {1'b0, stride_q};
    woff_d = (wsum >= {1'b0, wsize_q}) ? ADDR_W'(wsum - {1'b0, wsize_q}) : ADDR_W'(wsum);
    cur_d  = wbase_q + woff_d;
  end

  always_ff @(posedge clk) begin
    if (state_q == S_CHECK) begin
      wbase_q <= sel_base;
      wsize_q <= sel_size;
      woff_q  <= off_q;
    end else if (state_q == S_BURST && bus.addr_ready) begin
      woff_q  <= woff_d;
    end
  end
`else
  assign range_err = (burst_end(off_q, len_q, stride_q) >= EW'(sel_size));
  assign cur_d     = cur_q + stride_q;
`endif

  // ---- control registers: state, pulses, base map ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      for (int i = 0; i < N_REG; i++) base_q[i] <= MB_W'(DEF_BASE_MB[i]);
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      err_q   <= err_d;
      // Written on the same edge a request is latched, so CHECK sees it.
      if (state_q == S_IDLE && bus.cfg_we) begin
        for (int i = 0; i < N_REG; i++) begin
          if (bus.cfg_idx == RW'(i)) base_q[i] <= bus.cfg_base_mb;
        end
      end
    end
  end

  // ---- request latch and beat datapath ----
  always_ff @(posedge clk) begin
    if (state_q == S_IDLE && bus.req_valid) begin
      region_q <= bus.req_region;
      off_q    <= bus.req_off;
      len_q    <= bus.req_len;
      stride_q <= bus.req_stride;
    end
    if (state_q == S_CHECK) begin
      cur_q <= sel_base + off_q;
      cnt_q <= '0;
    end else if (state_q == S_BURST && bus.addr_ready) begin
      cur_q <= cur_d;
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // ---- next state ----
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) state_d = S_CHECK;
      end
      S_CHECK: begin
        if (len_zero) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else if (range_err) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else begin
          state_d = S_BURST;
        end
      end
      S_BURST: begin
        if (bus.addr_ready && last_beat) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---- outputs ----
  // done for a streamed burst coincides with the final handshake, so it
  // combines the registered last flag with addr_ready.
  always_comb begin
    bus.cfg_ready  = 1'b0;
    bus.req_ready  = 1'b0;
    bus.addr_valid = 1'b0;
    bus.addr       = '0;
    bus.addr_last  = 1'b0;
    bus.done       = done_q;
    bus.err        = err_q;
    case (state_q)
      S_IDLE: begin
        bus.cfg_ready = 1'b1;
        bus.req_ready = 1'b1;
      end
      S_BURST: begin
        bus.addr_valid = 1'b1;
        bus.addr       = cur_q;
        bus.addr_last  = last_beat;
        bus.done       = done_q | (bus.addr_ready & last_beat);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_region_addr_gen.sv
module tb_mem_region_addr_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_region_addr_gen_if bus ();

  mem_region_addr_gen dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Observations from one burst
  logic [31:0] q_addr [$];
  bit          q_last [$];
  bit          q_done [$];
  logic [31:0] exp_addr [$];
  bit          rdy_pat [$];
  int          first_v;
  bit          valid_seen, done_seen, err_seen, stable_ok;
  bit          cfg_poke, cfg_rdy_burst;
  logic        acc;

  task automatic issue(input logic [2:0] r, input logic [31:0] off,
                       input logic [15:0] len, input logic [31:0] st);
    @(posedge clk); #1;
    bus.req_valid  = 1'b1;
    bus.req_region = r;
    bus.req_off    = off;
    bus.req_len    = len;
    bus.req_stride = st;
    @(negedge clk);
    acc = bus.req_ready;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic collect(input int maxc);
    bit          held;
    logic [31:0] hold_addr;
    q_addr.delete(); q_last.delete(); q_done.delete();
    first_v = -1; valid_seen = 0; done_seen = 0; err_seen = 0;
    stable_ok = 1; held = 0; hold_addr = '0; cfg_rdy_burst = 1;
    for (int c = 0; c < maxc && !done_seen; c++) begin
      bus.addr_ready = (c < rdy_pat.size()) ? rdy_pat[c] : 1'b1;
      if (cfg_poke && c == 2) begin
        bus.cfg_we = 1'b1; bus.cfg_idx = 3'd2; bus.cfg_base_mb = 8'd24;
      end else begin
        bus.cfg_we = 1'b0;
      end
      @(negedge clk);
      if (cfg_poke && c == 2) cfg_rdy_burst = bus.cfg_ready;
      if (bus.addr_valid) begin
        if (!valid_seen) first_v = c;
        valid_seen = 1;
        if (held && bus.addr !== hold_addr) stable_ok = 0;
        if (bus.addr_ready) begin
          q_addr.push_back(bus.addr);
          q_last.push_back(bus.addr_last);
          q_done.push_back(bus.done);
          held = 0;
        end else begin
          held = 1;
          hold_addr = bus.addr;
        end
      end
      if (bus.done) begin
        done_seen = 1;
        err_seen  = bus.err;
      end
      @(posedge clk); #1;
    end
    bus.cfg_we = 1'b0;
    bus.addr_ready = 1'b0;
  endtask

  task automatic verify(input string tag, input bit exp_err);
    check({tag, "_done"}, done_seen, 1'b1);
    check({tag, "_err"}, err_seen, exp_err);
    check({tag, "_nbeats"}, q_addr.size(), exp_addr.size());
    if (q_addr.size() == exp_addr.size()) begin
      for (int i = 0; i < exp_addr.size(); i++) begin
        check($sformatf("%s_addr%0d", tag, i), q_addr[i], exp_addr[i]);
        check($sformatf("%s_last%0d", tag, i), q_last[i], i == exp_addr.size() - 1);
        check($sformatf("%s_dn%0d", tag, i), q_done[i], i == exp_addr.size() - 1);
      end
    end
    if (exp_addr.size() == 0) check({tag, "_novalid"}, valid_seen, 1'b0);
  endtask

  initial begin
    bus.cfg_we = 0; bus.cfg_idx = '0; bus.cfg_base_mb = '0;
    bus.req_valid = 0; bus.req_region = '0; bus.req_off = '0;
    bus.req_len = '0; bus.req_stride = '0; bus.addr_ready = 0;
    cfg_poke = 0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_cfg_ready", bus.cfg_ready, 1'b1);
    check("rst_req_ready", bus.req_ready, 1'b1);
    check("rst_addr_valid", bus.addr_valid, 1'b0);
    check("rst_addr", bus.addr, 32'h0);
    check("rst_addr_last", bus.addr_last, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_err", bus.err, 1'b0);

    // 1: default map, region 1 at 2 MiB
    issue(3'd1, 32'h10, 16'd4, 32'd4);
    check("t1_acc", acc, 1'b1);
    rdy_pat.delete();
    collect(40);
    exp_addr = '{32'h200010, 32'h200014, 32'h200018, 32'h20001C};
    verify("t1", 1'b0);
    check("t1_latency", first_v, 1);

    // 2: backpressure on region 5 (84 MiB); entry 0 is the CHECK cycle
    rdy_pat = '{1, 1, 0, 0, 1, 1};
    issue(3'd5, 32'h0, 16'd3, 32'h40);
    collect(40);
    rdy_pat.delete();
    exp_addr = '{32'h5400000, 32'h5400040, 32'h5400080};
    verify("t2", 1'b0);
    check("t2_stable", stable_ok, 1'b1);

    // 3: burst crossing the end of region 0 (2 MiB)
    issue(3'd0, 32'h1FFFF0, 16'd8, 32'd4);
    collect(40);
`ifdef ADDR_WRAP_EN
    exp_addr = '{32'h1FFFF0, 32'h1FFFF4, 32'h1FFFF8, 32'h1FFFFC,
                 32'h0, 32'h4, 32'h8, 32'hC};
    verify("t3", 1'b0);
`else
    exp_addr.delete();
    verify("t3", 1'b1);
`endif

    // 4: runtime base write grows region 1 to 28 MiB
    @(posedge clk); #1;
    bus.cfg_we = 1'b1; bus.cfg_idx = 3'd2; bus.cfg_base_mb = 8'd30;
    @(negedge clk);
    check("t4_cfg_ready", bus.cfg_ready, 1'b1);
    @(posedge clk); #1;
    bus.cfg_we = 1'b0;
    issue(3'd1, 32'h1BFFFFC, 16'd1, 32'd0);
    collect(40);
    exp_addr = '{32'h1DFFFFC};
    verify("t4a", 1'b0);
    cfg_poke = 1;
    issue(3'd1, 32'h0, 16'd3, 32'd4);
    collect(40);
    cfg_poke = 0;
    exp_addr = '{32'h200000, 32'h200004, 32'h200008};
    verify("t4b", 1'b0);
    check("t4_cfg_ready_burst", cfg_rdy_burst, 1'b0);
    issue(3'd1, 32'h1BFFFFC, 16'd1, 32'd0);
    collect(40);
    exp_addr = '{32'h1DFFFFC};
    verify("t4c", 1'b0);

    // 5: zero length and invalid region
    issue(3'd3, 32'h100, 16'd0, 32'd4);
    collect(40);
    exp_addr.delete();
    verify("t5a", 1'b0);
    issue(3'd7, 32'h0, 16'd1, 32'd4);
    collect(40);
    exp_addr.delete();
    verify("t5b", 1'b1);

    // 6: reset after two of five beats
    issue(3'd1, 32'h0, 16'd5, 32'd4);
    bus.addr_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("t6_beat0", bus.addr, 32'h200000);
    @(negedge clk);
    check("t6_beat1", bus.addr, 32'h200004);
    @(posedge clk); #1;
    rst_n = 1'b0;
    bus.addr_ready = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("t6_addr_valid", bus.addr_valid, 1'b0);
    check("t6_done", bus.done, 1'b0);
    check("t6_req_ready", bus.req_ready, 1'b1);
    // base[2] back to 24 MiB: region 1 is 22 MiB again
    issue(3'd1, 32'h1BFFFFC, 16'd1, 32'd0);
    collect(40);
    exp_addr.delete();
    verify("t6_default", 1'b1);
    issue(3'd1, 32'h10, 16'd4, 32'd4);
    collect(40);
    exp_addr = '{32'h200010, 32'h200014, 32'h200018, 32'h20001C};
    verify("t6_rerun", 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
